// File: rtl/zdos_pkg.sv
// zdos_pkg: shared types and constants for the DOS/shadow-ROM mode controller.
package zdos_pkg;

  localparam int DLY_W = 4;

  localparam logic [7:0] ENTRY_PAGE_DEF = 8'h3D;
  localparam logic [7:0] EXIT_LIMIT_DEF = 8'h40;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_ARM_ON  = 2'd1,
    ST_ON      = 2'd2,
    ST_ARM_OFF = 2'd3
  } zdos_state_e;

  // True while a delayed switch is waiting for its counter to expire.
  function automatic logic is_arm(input zdos_state_e s);
    return (s == ST_ARM_ON) || (s == ST_ARM_OFF);
  endfunction

endpackage

// File: rtl/zdos_ctrl_if.sv
// zdos_ctrl_if: bus-decoder side signals of the DOS mode controller.
// master = bus decoder / software pulse source, slave = zdos_ctrl.
interface zdos_ctrl_if #(
  parameter int FORCE_CNT = 2
);
  logic                 m1_fetch;
  logic [7:0]           m1_addr_hi;
  logic                 rom48_sel;
  logic                 dos_turn_on;
  logic                 dos_turn_off;
  logic [FORCE_CNT-1:0] force_on;
  logic                 dos;
  logic                 dos_pending;
  logic                 dos_change;
  logic [15:0]          dos_m1_cnt;

  modport master (
    output m1_fetch, m1_addr_hi, rom48_sel, dos_turn_on, dos_turn_off, force_on,
    input  dos, dos_pending, dos_change, dos_m1_cnt
  );

  modport slave (
    input  m1_fetch, m1_addr_hi, rom48_sel, dos_turn_on, dos_turn_off, force_on,
    output dos, dos_pending, dos_change, dos_m1_cnt
  );
endinterface

// File: rtl/zdos_dly.sv
// zdos_dly: loadable down-counter with zero flag, shared by both arm directions.
module zdos_dly
  import zdos_pkg::*;
(
  input  logic             fclk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [DLY_W-1:0] cnt;

  // Clear beats load beats decrement; the count parks at zero.
  always_ff @(posedge fclk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/zdos_ctrl.sv
// zdos_ctrl: DOS/shadow-ROM mode controller with force inputs, automatic
// entry/exit on M1 fetch addresses and programmable switch latency.
// Optional macro ZDOS_M1_CNT_EN adds a saturating DOS M1 fetch counter;
// without it dos_m1_cnt is tied to zero.
//
// state     | meaning
// ST_OFF    | DOS unmapped, watching for entry fetches
// ST_ARM_ON | entry seen, waiting ON_DELAY before mapping DOS
// ST_ON     | DOS mapped (reset state), watching for RAM execution
// ST_ARM_OFF| exit seen, waiting OFF_DELAY before unmapping DOS
module zdos_ctrl
  import zdos_pkg::*;
#(
  parameter int         FORCE_CNT  = 2,
  parameter logic [7:0] ENTRY_PAGE = ENTRY_PAGE_DEF,
  parameter logic [7:0] EXIT_LIMIT = EXIT_LIMIT_DEF,
  parameter int         ON_DELAY   = 1,
  parameter int         OFF_DELAY  = 1
) (
  input  logic        fclk,
  input  logic        rst,
  zdos_ctrl_if.slave  bus
);

  if (FORCE_CNT < 1 || FORCE_CNT > 8) begin : g_bad_force_cnt
    $error("zdos_ctrl: FORCE_CNT must be 1..8");
  end
  if (ON_DELAY < 0 || ON_DELAY > 15) begin : g_bad_on_delay
    $error("zdos_ctrl: ON_DELAY must be 0..15");
  end
  if (OFF_DELAY < 0 || OFF_DELAY > 15) begin : g_bad_off_delay
    $error("zdos_ctrl: OFF_DELAY must be 0..15");
  end

  // Arming loads delay-1 so the switch lands exactly DELAY edges after arming.
  localparam logic [DLY_W-1:0] ON_LD  = (ON_DELAY  > 0) ? DLY_W'(ON_DELAY  - 1) : '0;
  localparam logic [DLY_W-1:0] OFF_LD = (OFF_DELAY > 0) ? DLY_W'(OFF_DELAY - 1) : '0;

  zdos_state_e      st_q, st_nxt;
  logic             dos_r, dos_prev, dos_change_r, dos_nxt;
  logic             force_any, entry_hit, exit_hit;
  logic             dly_clr, dly_load, dly_dec, dly_zero;
  logic [DLY_W-1:0] dly_val;

  assign force_any = |bus.force_on;
  assign entry_hit = bus.m1_fetch && (bus.m1_addr_hi == ENTRY_PAGE) && bus.rom48_sel;
  assign exit_hit  = bus.m1_fetch && (bus.m1_addr_hi >= EXIT_LIMIT);

  // Next state: force, then off pulse, then on pulse, then auto events, then expiry.
  always_comb begin
    st_nxt   = st_q;
    dly_load = 1'b0;
    dly_val  = '0;
    if (force_any) begin
      st_nxt = ST_ON;
    end else if (bus.dos_turn_off) begin
      st_nxt = ST_OFF;
    end else if (bus.dos_turn_on) begin
      st_nxt = ST_ON;
    end else begin
      case (st_q)
        ST_OFF: begin
          if (entry_hit) begin
            if (ON_DELAY == 0) begin
              st_nxt = ST_ON;
            end else begin
              st_nxt   = ST_ARM_ON;
              dly_load = 1'b1;
              dly_val  = ON_LD;
            end
          end
        end
        ST_ON: begin
          if (exit_hit) begin
            if (OFF_DELAY == 0) begin
              st_nxt = ST_OFF;
            end else begin
              st_nxt   = ST_ARM_OFF;
              dly_load = 1'b1;
              dly_val  = OFF_LD;
            end
          end
        end
        ST_ARM_ON: begin
          if (exit_hit) begin
            st_nxt = ST_OFF;
          end else if (dly_zero) begin
            st_nxt = ST_ON;
          end
        end
        ST_ARM_OFF: begin
          if (entry_hit) begin
            st_nxt = ST_ON;
          end else if (dly_zero) begin
            st_nxt = ST_OFF;
          end
        end
        default: st_nxt = ST_ON;
      endcase
    end
  end

  // Counter only runs while staying in an arm state; any exit clears it.
  always_comb begin
    dly_clr = !is_arm(st_nxt);
    dly_dec = is_arm(st_q) && is_arm(st_nxt) && !dly_load;
    dos_nxt = (st_nxt == ST_ON) || (st_nxt == ST_ARM_OFF);
  end

  zdos_dly u_dly (
    .fclk     (fclk),
    .rst      (rst),
    .clr      (dly_clr),
    .load     (dly_load),
    .load_val (dly_val),
    .dec      (dly_dec),
    .zero     (dly_zero)
  );

  // State, dos flag and toggle detector; dos_prev resets to 1 so release is silent.
  always_ff @(posedge fclk) begin
    if (rst) begin
      st_q         <= ST_ON;
      dos_r        <= 1'b1;
      dos_prev     <= 1'b1;
      dos_change_r <= 1'b0;
    end else begin
      st_q         <= st_nxt;
      dos_r        <= dos_nxt;
      dos_prev     <= dos_r;
      dos_change_r <= dos_r ^ dos_prev;
    end
  end

  assign bus.dos         = dos_r;
  assign bus.dos_pending = is_arm(st_q);
  assign bus.dos_change  = dos_change_r;

`ifdef ZDOS_M1_CNT_EN
  logic [15:0] m1_cnt;

  // Count fetches spent in DOS; every DOS entry restarts from zero.
  always_ff @(posedge fclk) begin
    if (rst) begin
      m1_cnt <= '0;
    end else if (dos_nxt && !dos_r) begin
      m1_cnt <= '0;
    end else if (bus.m1_fetch && dos_r && (m1_cnt != 16'hFFFF)) begin
      m1_cnt <= m1_cnt + 16'd1;
    end
  end

  assign bus.dos_m1_cnt = m1_cnt;
`else
  assign bus.dos_m1_cnt = '0;
`endif

endmodule

// File: tb/tb_zdos_ctrl.sv
// tb_zdos_ctrl: table-driven check of zdos_ctrl. Instance a uses ON_DELAY=1,
// OFF_DELAY=3; instance b uses zero delays and sees the same stimulus.
module tb_zdos_ctrl;
  import zdos_pkg::*;

  logic fclk = 1'b0;
  logic rst;
  always #5 fclk = ~fclk;

  zdos_ctrl_if #(.FORCE_CNT(2)) ifa ();
  zdos_ctrl_if #(.FORCE_CNT(2)) ifb ();

  assign ifb.m1_fetch     = ifa.m1_fetch;
  assign ifb.m1_addr_hi   = ifa.m1_addr_hi;
  assign ifb.rom48_sel    = ifa.rom48_sel;
  assign ifb.dos_turn_on  = ifa.dos_turn_on;
  assign ifb.dos_turn_off = ifa.dos_turn_off;
  assign ifb.force_on     = ifa.force_on;

  zdos_ctrl #(.FORCE_CNT(2), .ON_DELAY(1), .OFF_DELAY(3)) dut_a (
    .fclk (fclk),
    .rst  (rst),
    .bus  (ifa)
  );

  zdos_ctrl #(.FORCE_CNT(2), .ON_DELAY(0), .OFF_DELAY(0)) dut_b (
    .fclk (fclk),
    .rst  (rst),
    .bus  (ifb)
  );

  typedef struct {
    logic       rst, off, on, f;
    logic [7:0] hi;
    logic       rom;
    logic [1:0] frc;
    logic       a_dos, a_pend, a_chg, b_dos;
  } vec_t;

  typedef struct {
    logic a_dos, a_pend, a_chg, b_dos;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, o, n, f, input logic [7:0] hi, input logic rom,
                     input logic [1:0] frc, input logic ad, ap, ac, bd);
    vec_t v;
    v.rst = r; v.off = o; v.on = n; v.f = f; v.hi = hi; v.rom = rom; v.frc = frc;
    v.a_dos = ad; v.a_pend = ap; v.a_chg = ac; v.b_dos = bd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, o, n, f, input logic [7:0] hi, input logic rom,
                       input logic [1:0] frc);
    rst              = r;
    ifa.dos_turn_off = o;
    ifa.dos_turn_on  = n;
    ifa.m1_fetch     = f;
    ifa.m1_addr_hi   = hi;
    ifa.rom48_sel    = rom;
    ifa.force_on     = frc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    vec_t v;

    //  rst off on  f   hi    rom frc    a_dos pend chg b_dos
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);        // 0-4 idle after reset
    add(0, 1, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 0);          // 5 turn_off
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 0);          // 6 change pulse
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 0);          // 7
    add(0, 0, 0, 1, 8'h3D, 1, 2'b00, 0, 1, 0, 1);          // 8 entry fetch, arm
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 9 ON
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 1, 1);          // 10 change pulse
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 11
    add(0, 0, 0, 1, 8'h80, 0, 2'b00, 1, 1, 0, 0);          // 12 exit fetch, OFF_DELAY=3
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 1, 0, 0);          // 13
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 1, 0, 0);          // 14
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 0);          // 15 OFF
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 0);          // 16
    add(0, 0, 0, 1, 8'h3D, 1, 2'b00, 0, 1, 0, 1);          // 17 entry
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 18
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 1, 1);          // 19
    add(0, 0, 0, 1, 8'h90, 0, 2'b00, 1, 1, 0, 0);          // 20 exit arm
    add(0, 0, 0, 1, 8'h3D, 1, 2'b00, 1, 0, 0, 1);          // 21 cancel back to ON
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);        // 22-25 stays ON
    add(0, 0, 0, 1, 8'hA0, 0, 2'b00, 1, 1, 0, 0);          // 26 exit arm
    add(0, 0, 0, 1, 8'h3D, 0, 2'b00, 1, 1, 0, 0);          // 27 no rom48: ignored
    add(0, 0, 0, 1, 8'h20, 0, 2'b00, 1, 1, 0, 0);          // 28 low page: ignored
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 0);          // 29 OFF, no restart
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 0);          // 30
    add(0, 0, 0, 1, 8'h3D, 1, 2'b00, 0, 1, 0, 1);          // 31 entry arm
    add(0, 0, 0, 1, 8'h40, 0, 2'b00, 0, 0, 0, 0);          // 32 limit fetch cancels
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 0);          // 33
    add(0, 1, 0, 1, 8'hC0, 0, 2'b10, 1, 0, 0, 1);          // 34 force beats off/exit
    add(0, 1, 0, 0, 8'h00, 0, 2'b10, 1, 0, 1, 1);          // 35
    add(0, 0, 0, 1, 8'hC0, 0, 2'b10, 1, 0, 0, 1);          // 36
    add(0, 1, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 0);          // 37 released: off
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 0);          // 38
    add(0, 0, 1, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 39 turn_on
    add(0, 1, 1, 0, 8'h00, 0, 2'b00, 0, 0, 1, 0);          // 40 both: off wins
    add(0, 0, 1, 1, 8'h80, 0, 2'b00, 1, 0, 1, 1);          // 41 turn_on beats exit
    add(0, 0, 0, 1, 8'h3F, 0, 2'b00, 1, 0, 1, 1);          // 42 just below limit
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 43
    add(0, 0, 0, 1, 8'hFF, 0, 2'b01, 1, 0, 0, 1);          // 44 force bit 0
    add(0, 1, 0, 0, 8'h00, 0, 2'b00, 0, 0, 0, 0);          // 45 off
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 0, 0, 1, 0);          // 46
    add(0, 0, 0, 1, 8'h3D, 1, 2'b00, 0, 1, 0, 1);          // 47 arm on
    add(1, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 48 reset mid ARM_ON
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 49 no pulse
    add(0, 0, 0, 1, 8'hFF, 0, 2'b00, 1, 1, 0, 0);          // 50 arm off
    add(1, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 51 reset mid ARM_OFF
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 52
    add(0, 0, 0, 0, 8'h00, 0, 2'b00, 1, 0, 0, 1);          // 53

    drive(1, 0, 0, 0, 8'h00, 0, 2'b00);
    @(posedge fclk);
    @(posedge fclk);
    #1;
    chk("reset a_dos",    {15'd0, ifa.dos},         16'd1);
    chk("reset a_pend",   {15'd0, ifa.dos_pending}, 16'd0);
    chk("reset a_chg",    {15'd0, ifa.dos_change},  16'd0);
    chk("reset a_m1cnt",  ifa.dos_m1_cnt,           16'd0);
    chk("reset b_dos",    {15'd0, ifb.dos},         16'd1);
    chk("reset b_chg",    {15'd0, ifb.dos_change},  16'd0);
    chk("reset b_m1cnt",  ifb.dos_m1_cnt,           16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      drive(v.rst, v.off, v.on, v.f, v.hi, v.rom, v.frc);
      e.a_dos = v.a_dos; e.a_pend = v.a_pend; e.a_chg = v.a_chg; e.b_dos = v.b_dos;
      sb_q.push_back(e);
      @(posedge fclk);
      #1;
      e = sb_q.pop_front();
      chk($sformatf("row%0d a_dos", i),  {15'd0, ifa.dos},         {15'd0, e.a_dos});
      chk($sformatf("row%0d a_pend", i), {15'd0, ifa.dos_pending}, {15'd0, e.a_pend});
      chk($sformatf("row%0d a_chg", i),  {15'd0, ifa.dos_change},  {15'd0, e.a_chg});
      chk($sformatf("row%0d b_dos", i),  {15'd0, ifb.dos},         {15'd0, e.b_dos});
      chk($sformatf("row%0d b_pend", i), {15'd0, ifb.dos_pending}, 16'd0);
    end

`ifdef ZDOS_M1_CNT_EN
    drive(0, 0, 0, 1, 8'h00, 0, 2'b00);
    for (int k = 0; k < 70000; k++) @(posedge fclk);
    #1;
    chk("sat a_m1cnt", ifa.dos_m1_cnt, 16'hFFFF);
    chk("sat b_m1cnt", ifb.dos_m1_cnt, 16'hFFFF);
    drive(0, 1, 0, 0, 8'h00, 0, 2'b00);
    @(posedge fclk);
    #1;
    chk("off a_dos",    {15'd0, ifa.dos}, 16'd0);
    chk("off a_m1cnt",  ifa.dos_m1_cnt,   16'hFFFF);
    drive(0, 0, 1, 1, 8'h00, 0, 2'b00);
    @(posedge fclk);
    #1;
    chk("on a_dos",     {15'd0, ifa.dos}, 16'd1);
    chk("clr a_m1cnt",  ifa.dos_m1_cnt,   16'd0);
    chk("clr b_m1cnt",  ifb.dos_m1_cnt,   16'd0);
    drive(0, 0, 0, 1, 8'h00, 0, 2'b00);
    @(posedge fclk);
    #1;
    chk("one a_m1cnt",  ifa.dos_m1_cnt,   16'd1);
`else
    drive(0, 0, 0, 1, 8'h00, 0, 2'b00);
    for (int k = 0; k < 20; k++) @(posedge fclk);
    #1;
    chk("tied a_m1cnt", ifa.dos_m1_cnt, 16'd0);
    chk("tied b_m1cnt", ifb.dos_m1_cnt, 16'd0);
`endif
    drive(0, 0, 0, 0, 8'h00, 0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
